// File: rtl/lexington_pkg.sv
// rtl/lexington_pkg.sv - register map constants and CTRL layout shared by the gptim_mc timer
package lexington_pkg;

    localparam int MAX_CHANNELS = 4;
    localparam int CH_OFS_BITS  = 4;
    localparam int GPTIM_AW     = $clog2(MAX_CHANNELS) + CH_OFS_BITS;

    localparam logic [1:0] OFF_CTRL = 2'd0;
    localparam logic [1:0] OFF_CNT  = 2'd1;
    localparam logic [1:0] OFF_ARR  = 2'd2;
    localparam logic [1:0] OFF_CMP  = 2'd3;

    typedef struct packed {
        logic [7:0] psc;
        logic [3:0] rsvd;
        logic       if_flag;
        logic       ie;
        logic       oneshot;
        logic       en;
    } ctrl_t;

    function automatic int addr_width(input int channels);
        return $clog2(channels) + CH_OFS_BITS;
    endfunction

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        ctrl_t r;
        r      = c;
        r.rsvd = '0;
        return {16'h0000, r};
    endfunction

endpackage

// File: rtl/gptim_channel.sv
// rtl/gptim_channel.sv - one timer channel: prescaler, up-counter with auto-reload, flags, compare
// Compare register and pwm output exist only when GPTIM_PWM_EN is defined.
module gptim_channel
    import lexington_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_ctrl,
    input  logic             wr_cnt,
    input  logic             wr_arr,
    input  logic             wr_cmp,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strobe,
    output ctrl_t            ctrl,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] arr,
    output logic [WIDTH-1:0] cmp,
    output logic             irq,
    output logic             pwm
);

    logic [7:0]       psc_cnt;
    logic             tick;
    logic             wrap;
    logic             if_clr;
    ctrl_t            ctrl_next;
    logic [31:0]      bmask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wdat;
    logic             unused_wr;

    assign bmask = {{8{wr_strobe[3]}}, {8{wr_strobe[2]}}, {8{wr_strobe[1]}}, {8{wr_strobe[0]}}};
    assign wmask = bmask[WIDTH-1:0];
    assign wdat  = wr_data[WIDTH-1:0];
    assign unused_wr = ^{wr_data, bmask};

    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old);
        return (old & ~wmask) | (wdat & wmask);
    endfunction

    assign tick   = ctrl.en && (psc_cnt == ctrl.psc);
    // A CNT write in the same cycle swallows the tick, so it can never wrap.
    assign wrap   = tick && !wr_cnt && (cnt == arr);
    assign if_clr = wr_ctrl && wr_strobe[0] && wr_data[3];
    assign irq    = ctrl.if_flag && ctrl.ie;

    always_comb begin
        ctrl_next = ctrl;
        if (wrap && ctrl.oneshot) begin
            ctrl_next.en = 1'b0;
        end
        if (wr_ctrl && wr_strobe[0]) begin
            ctrl_next.en      = wr_data[0];
            ctrl_next.oneshot = wr_data[1];
            ctrl_next.ie      = wr_data[2];
        end
        if (wr_ctrl && wr_strobe[1]) begin
            ctrl_next.psc = wr_data[15:8];
        end
        ctrl_next.if_flag = wrap || (ctrl.if_flag && !if_clr);
        ctrl_next.rsvd    = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl    <= '0;
            cnt     <= '0;
            arr     <= '1;
            psc_cnt <= '0;
        end else begin
            ctrl <= ctrl_next;
            if (wr_ctrl || !ctrl.en || tick) begin
                psc_cnt <= '0;
            end else begin
                psc_cnt <= psc_cnt + 8'd1;
            end
            if (wr_cnt) begin
                cnt <= merge(cnt);
            end else if (tick) begin
                cnt <= (cnt == arr) ? '0 : cnt + WIDTH'(1);
            end
            if (wr_arr) begin
                arr <= merge(arr);
            end
        end
    end

`ifdef GPTIM_PWM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp <= '0;
            pwm <= 1'b0;
        end else begin
            if (wr_cmp) begin
                cmp <= merge(cmp);
            end
            pwm <= ctrl.en && (cnt < cmp);
        end
    end
`else
    logic unused_cmp;
    assign unused_cmp = wr_cmp;
    assign cmp        = '0;
    assign pwm        = 1'b0;
`endif

endmodule

// File: rtl/gptim_mc.sv
// rtl/gptim_mc.sv - multi-channel general-purpose timer: address decode, read mux, channel array
// Optional compare/pwm feature is enabled by defining GPTIM_PWM_EN.
module gptim_mc
    import lexington_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     rd_en,
    input  logic                                     wr_en,
    input  logic [$clog2(CHANNELS)+CH_OFS_BITS-1:0]  addr,
    input  logic [31:0]                              wr_data,
    input  logic [3:0]                               wr_strobe,
    output logic [31:0]                              rd_data,
    output logic [CHANNELS-1:0]                      irq,
    output logic [CHANNELS-1:0]                      pwm
);

    logic [31:0]      ch_sel;
    logic [1:0]       off;
    logic [31:0]      rd_mux;
    logic             unused_addr;
    ctrl_t            ch_ctrl [CHANNELS];
    logic [WIDTH-1:0] ch_cnt  [CHANNELS];
    logic [WIDTH-1:0] ch_arr  [CHANNELS];
    logic [WIDTH-1:0] ch_cmp  [CHANNELS];

    // Channel indices at or beyond CHANNELS match no generate slot, so they read 0 and drop writes.
    assign ch_sel      = 32'(addr >> CH_OFS_BITS);
    assign off         = addr[3:2];
    assign unused_addr = ^addr[1:0];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic hit;
        assign hit = wr_en && (ch_sel == 32'(g));

        gptim_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_ctrl  (hit && (off == OFF_CTRL)),
            .wr_cnt   (hit && (off == OFF_CNT)),
            .wr_arr   (hit && (off == OFF_ARR)),
            .wr_cmp   (hit && (off == OFF_CMP)),
            .wr_data  (wr_data),
            .wr_strobe(wr_strobe),
            .ctrl     (ch_ctrl[g]),
            .cnt      (ch_cnt[g]),
            .arr      (ch_arr[g]),
            .cmp      (ch_cmp[g]),
            .irq      (irq[g]),
            .pwm      (pwm[g])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == 32'(i)) begin
                case (off)
                    OFF_CTRL: rd_mux = ctrl_word(ch_ctrl[i]);
                    OFF_CNT:  rd_mux = 32'(ch_cnt[i]);
                    OFF_ARR:  rd_mux = 32'(ch_arr[i]);
                    OFF_CMP:  rd_mux = 32'(ch_cmp[i]);
                    default:  rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_gptim_mc.sv
// tb/tb_gptim_mc.sv - self-checking bench for gptim_mc against a behavioural register model
module tb_gptim_mc;

    localparam int CH = 2;
    localparam int AW = 5;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          rd_en     = 1'b0;
    logic          wr_en     = 1'b0;
    logic [AW-1:0] addr      = '0;
    logic [31:0]   wr_data   = '0;
    logic [3:0]    wr_strobe = '0;
    logic [31:0]   rd_data;
    logic [CH-1:0] irq;
    logic [CH-1:0] pwm;

    always #5 clk = ~clk;

    gptim_mc #(
        .CHANNELS(CH),
        .WIDTH   (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .addr     (addr),
        .wr_data  (wr_data),
        .wr_strobe(wr_strobe),
        .rd_data  (rd_data),
        .irq      (irq),
        .pwm      (pwm)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_cnt [CH];
    logic [31:0] m_arr [CH];
    logic [31:0] m_cmp [CH];
    logic [7:0]  m_psc [CH];
    bit          m_en  [CH];
    bit          m_os  [CH];
    bit          m_ie  [CH];
    bit          m_if  [CH];
    int          m_ph  [CH];
    logic [31:0] m_rd;
    logic [CH-1:0] m_pwm;
    bit          m_valid = 1'b0;

    int t1_cnt [6] = '{0, 1, 2, 3, 4, 0};
    int t1_irq [6] = '{0, 0, 0, 0, 1, 1};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_ctrl(input int c);
        return {16'h0000, m_psc[c], 4'h0, m_if[c], m_ie[c], m_os[c], m_en[c]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            m_cnt[k] = '0;
            m_arr[k] = 32'hFFFF_FFFF;
            m_cmp[k] = '0;
            m_psc[k] = '0;
            m_en[k]  = 1'b0;
            m_os[k]  = 1'b0;
            m_ie[k]  = 1'b0;
            m_if[k]  = 1'b0;
            m_ph[k]  = 0;
        end
        m_rd    = '0;
        m_pwm   = '0;
        m_valid = 1'b1;
    endtask

    task automatic model_step();
        int          c;
        logic [1:0]  o;
        logic [31:0] mask;
        bit          wctrl, wcnt, warr, wcmp, tick, wrapped;
        c    = int'(addr >> 4);
        o    = addr[3:2];
        mask = {{8{wr_strobe[3]}}, {8{wr_strobe[2]}}, {8{wr_strobe[1]}}, {8{wr_strobe[0]}}};
        if (rd_en) begin
            case (o)
                2'd0:    m_rd = m_ctrl(c);
                2'd1:    m_rd = m_cnt[c];
                2'd2:    m_rd = m_arr[c];
`ifdef GPTIM_PWM_EN
                default: m_rd = m_cmp[c];
`else
                default: m_rd = 32'h0;
`endif
            endcase
        end
        for (int k = 0; k < CH; k++) begin
            wctrl   = wr_en && (c == k) && (o == 2'd0);
            wcnt    = wr_en && (c == k) && (o == 2'd1);
            warr    = wr_en && (c == k) && (o == 2'd2);
            wcmp    = wr_en && (c == k) && (o == 2'd3);
            tick    = m_en[k] && ((m_ph[k] % (m_psc[k] + 1)) == m_psc[k]);
            wrapped = tick && !wcnt && (m_cnt[k] == m_arr[k]);
`ifdef GPTIM_PWM_EN
            m_pwm[k] = m_en[k] && (m_cnt[k] < m_cmp[k]);
            if (wcmp) m_cmp[k] = (m_cmp[k] & ~mask) | (wr_data & mask);
`else
            m_pwm[k] = 1'b0;
            if (wcmp) m_cmp[k] = '0;
`endif
            m_ph[k] = (wctrl || !m_en[k]) ? 0 : m_ph[k] + 1;
            if (wcnt)      m_cnt[k] = (m_cnt[k] & ~mask) | (wr_data & mask);
            else if (tick) m_cnt[k] = (m_cnt[k] == m_arr[k]) ? 32'h0 : m_cnt[k] + 32'h1;
            if (warr)      m_arr[k] = (m_arr[k] & ~mask) | (wr_data & mask);
            if (wrapped && m_os[k]) m_en[k] = 1'b0;
            m_if[k] = wrapped || (m_if[k] && !(wctrl && wr_strobe[0] && wr_data[3]));
            if (wctrl && wr_strobe[0]) begin
                m_en[k] = wr_data[0];
                m_os[k] = wr_data[1];
                m_ie[k] = wr_data[2];
            end
            if (wctrl && wr_strobe[1]) m_psc[k] = wr_data[15:8];
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) model_reset();
        else     model_step();
    end

    initial forever begin
        logic [CH-1:0] exp_irq;
        @(negedge clk);
        if (m_valid) begin
            for (int k = 0; k < CH; k++) exp_irq[k] = m_if[k] && m_ie[k];
            chk("model_rd_data", rd_data, m_rd);
            chk("model_irq", 32'(irq), 32'(exp_irq));
            chk("model_pwm", 32'(pwm), 32'(m_pwm));
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        addr      = a;
        wr_data   = d;
        wr_strobe = s;
        wr_en     = 1'b1;
        rd_en     = 1'b0;
        @(negedge clk);
        wr_en     = 1'b0;
        wr_strobe = 4'h0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] v);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        v     = rd_data;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int hi;

        // ch0: ARR=4, PSC=0 counts 0..4 and wraps with IF
        do_reset();
        chk("reset_rd_data", rd_data, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        wr(5'h08, 32'd4, 4'hF);
        wr(5'h00, 32'h5, 4'hF);
        addr  = 5'h04;
        rd_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1_cnt", rd_data, 32'(t1_cnt[k]));
            chk("t1_irq", 32'(irq[0]), 32'(t1_irq[k]));
        end
        rd_en = 1'b0;

        // ch1: PSC=2, ARR=1, oneshot -> irq after 6 cycles, EN drops
        do_reset();
        wr(5'h18, 32'd1, 4'hF);
        wr(5'h10, 32'h207, 4'hF);
        chk("t2_irq_early", 32'(irq[1]), 32'h0);
        for (int k = 2; k < 8; k++) begin
            @(negedge clk);
            chk("t2_irq_rise", 32'(irq[1]), (k == 7) ? 32'h1 : 32'h0);
        end
        rd(5'h10, v);
        chk("t2_ctrl", v, 32'h20E);
        rd(5'h14, v);
        chk("t2_cnt_hold", v, 32'h0);

        // IF clear coinciding with a wrap loses to the set
        do_reset();
        wr(5'h08, 32'd4, 4'hF);
        wr(5'h00, 32'h5, 4'hF);
        repeat (9) @(negedge clk);
        chk("t3_if_pre", 32'(irq[0]), 32'h1);
        wr(5'h00, 32'hD, 4'h1);
        chk("t3_set_wins", 32'(irq[0]), 32'h1);
        wr(5'h00, 32'hD, 4'h1);
        chk("t3_clear", 32'(irq[0]), 32'h0);

        // CNT write on the wrap tick
        do_reset();
        wr(5'h08, 32'd4, 4'hF);
        wr(5'h00, 32'h5, 4'hF);
        repeat (4) @(negedge clk);
        wr(5'h04, 32'd7, 4'hF);
        rd(5'h04, v);
        chk("t4_cnt", v, 32'd7);
        chk("t4_irq", 32'(irq[0]), 32'h0);
        rd(5'h00, v);
        chk("t4_ctrl", v, 32'h5);
        wr(5'h00, 32'h0, 4'hF);

`ifdef GPTIM_PWM_EN
        do_reset();
        wr(5'h08, 32'd9, 4'hF);
        wr(5'h0C, 32'd3, 4'hF);
        wr(5'h00, 32'h1, 4'hF);
        hi = 0;
        repeat (20) begin
            @(negedge clk);
            hi += int'(pwm[0]);
        end
        chk("t5_pwm_duty", 32'(hi), 32'd6);
        wr(5'h0C, 32'd0, 4'hF);
        repeat (2) @(negedge clk);
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            hi += int'(pwm[0]);
        end
        chk("t5_cmp0_low", 32'(hi), 32'd0);
        wr(5'h0C, 32'd20, 4'hF);
        repeat (2) @(negedge clk);
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            hi += int'(pwm[0]);
        end
        chk("t5_cmp_gt_arr_high", 32'(hi), 32'd10);
        rd(5'h0C, v);
        chk("t5_cmp_read", v, 32'd20);
`else
        do_reset();
        wr(5'h0C, 32'd3, 4'hF);
        rd(5'h0C, v);
        chk("t5_cmp_reads_0", v, 32'h0);
        chk("t5_pwm_tied", 32'(pwm), 32'h0);
`endif

        // async reset mid-count with IF pending
        do_reset();
        wr(5'h08, 32'd2, 4'hF);
        wr(5'h00, 32'h5, 4'hF);
        repeat (4) @(negedge clk);
        addr  = 5'h00;
        rd_en = 1'b1;
        @(negedge clk);
        chk("t6_pre_irq", 32'(irq[0]), 32'h1);
        chk("t6_pre_ctrl", rd_data, 32'hD);
        #2 rst = 1'b1;
        #1;
        chk("t6_rd_data_async", rd_data, 32'h0);
        chk("t6_irq_async", 32'(irq), 32'h0);
        chk("t6_pwm_async", 32'(pwm), 32'h0);
        @(negedge clk);
        rst   = 1'b0;
        rd_en = 1'b0;
        rd(5'h08, v);
        chk("t6_arr_reset", v, 32'hFFFF_FFFF);
        chk("t6_irq_after", 32'(irq), 32'h0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            wr_en     = ($urandom_range(0, 3) == 0);
            rd_en     = $urandom_range(0, 1);
            addr      = AW'($urandom_range(0, 31));
            wr_strobe = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            if (addr[3:2] == 2'd0)
                wr_data = ($urandom_range(0, 3) << 8) | $urandom_range(0, 15);
            else
                wr_data = ($urandom_range(0, 31) == 0) ? $urandom : $urandom_range(0, 9);
            if (i == 2000) begin
                #3 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            @(negedge clk);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gptim_mc.md
GPTIM_MC -- requirements
Module: gptim_mc

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, meaning the number of independent timer channels (1..4).
REQ-002 SHALL have parameter WIDTH, default 32, meaning the counter, ARR and CMP width in bits (8..32).
REQ-003 SHALL have port clk, input, 1, meaning the core clock; the block has one clock.
REQ-004 SHALL have port rst, input, 1, meaning reset, which is asynchronous and active-high.
REQ-005 SHALL have port rd_en, input, 1, meaning a register read strobe.
REQ-006 SHALL have port wr_en, input, 1, meaning a register write strobe.
REQ-007 SHALL have port addr, input, $clog2(CHANNELS)+4, meaning the byte address; bits [1:0] are ignored.
REQ-008 SHALL have port wr_data, input, 32, meaning the write data.
REQ-009 SHALL have port wr_strobe, input, 4, meaning the byte enables for wr_data.
REQ-010 SHALL have port rd_data, output, 32, meaning the read data.
REQ-011 SHALL have port irq, output, CHANNELS, meaning the per-channel interrupt, equal to IF & IE.
REQ-012 SHALL have port pwm, output, CHANNELS, meaning the per-channel compare output.

Function
REQ-013 Each channel SHALL occupy 16 bytes at base ch*16, with words CTRL +0, CNT +4, ARR +8 and CMP +C.
REQ-014 CTRL SHALL have bits [0] EN, [1] ONESHOT, [2] IE, [3] IF and [15:8] PSC; all other bits read 0.
REQ-015 Each channel SHALL run a private prescaler that produces a tick every PSC+1 cycles while EN=1.
REQ-016 The prescaler SHALL clear when EN=0 and on any write to CTRL.
REQ-017 On a tick with CNT≠ARR, CNT SHALL increment by 1.
REQ-018 On a tick with CNT==ARR, CNT SHALL become 0 and IF SHALL become 1; if ONESHOT=1, EN SHALL also become 0 in the same cycle.
REQ-019 ARR=0 SHALL produce an update on every tick.
REQ-020 IF SHALL be cleared by writing 1 to CTRL[3]; writing 0 to CTRL[3] SHALL have no effect.
REQ-021 If a hardware IF set coincides with a software IF clear, the set SHALL win.
REQ-022 A CPU write to CNT SHALL take priority over a same-cycle tick and SHALL suppress that tick's update.
REQ-023 Writes SHALL honour wr_strobe per byte; bits at and above WIDTH are ignored on write and read 0.
REQ-024 Reads SHALL have 1-cycle latency: rd_data is registered from addr in the rd_en cycle.
REQ-025 rd_data SHALL hold its value when rd_en=0.
REQ-026 Reads of unmapped channels or offsets SHALL return 0, and writes to them SHALL be ignored.
REQ-027 Each irq bit SHALL be combinational from the registered IF and IE.

Reset
REQ-028 rst SHALL asynchronously clear CTRL, CNT, CMP, the prescalers, rd_data, irq and pwm, and SHALL set ARR to all ones.
REQ-029 Reset asserted mid-count SHALL abort the count with no pending IF after release.

Configuration
REQ-030 With GPTIM_PWM_EN defined, pwm[ch] SHALL be registered as EN && (CNT < CMP) and CMP SHALL be read/write.
REQ-031 With GPTIM_PWM_EN defined, CMP=0 SHALL hold pwm low and CMP>ARR SHALL hold pwm high while enabled.
REQ-032 Without GPTIM_PWM_EN, pwm SHALL be tied 0, CMP SHALL read 0, CMP writes SHALL be ignored, and no compare logic SHALL be synthesised.

Structure
REQ-033 The lexington package SHALL hold the register offset constants, a packed CTRL struct typedef and the channel limit of 4.
REQ-034 The lexington package SHALL hold the widened address-width constant in place of the fixed 4-bit GPTIM width.
REQ-035 The per-channel logic (prescaler, counter, flags, compare) SHALL be sub-module gptim_channel, instantiated CHANNELS times with a generate loop.
REQ-036 Top-level address decode and the read mux SHALL be implemented in gptim_mc.

Verification
REQ-037 The bench SHALL cover: ch0 with ARR=4, PSC=0, EN=1 -> CNT 0,1,2,3,4,0 on consecutive cycles, with IF set on the wrap cycle.
REQ-038 The bench SHALL cover: ch1 with PSC=2, ARR=1, ONESHOT=1, IE=1 -> irq[1] rises 6 cycles after enable, EN reads 0, and CNT holds 0.
REQ-039 The bench SHALL cover: a write of 1 to CTRL[3] in the same cycle as a wrap -> IF remains 1.
REQ-040 The bench SHALL cover: a CNT write of 7 coinciding with a tick at CNT==ARR -> CNT=7 and IF unchanged.
REQ-041 The bench SHALL cover: with GPTIM_PWM_EN, ARR=9 and CMP=3 -> pwm high for 3 of every 10 cycles; without the macro, CMP reads 0.
REQ-042 The bench SHALL cover: rst asserted mid-count with IF=1 -> all outputs are 0 immediately, ARR reads 0xFFFFFFFF, and irq=0 after release.
